// File: rtl/xorshift_sched.sv
// Round-robin front end sharing one xorshift32 generator among NUM_REQ seed
// requesters; each granted job streams OUT_NUM words tagged with its owner.
module xorshift_sched #(
    parameter int NUM_REQ = 2,
    parameter int OUT_NUM = 256,
    parameter int ID_W    = (NUM_REQ <= 2) ? 1 : $clog2(NUM_REQ)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [32*NUM_REQ-1:0]  req_seed,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [31:0]            rand_num,
    output logic [ID_W-1:0]        out_id,
    output logic                   busy
);

    localparam int                CNT_W    = $clog2(OUT_NUM) + 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(OUT_NUM - 1);
    localparam logic [ID_W-1:0]   ID_LAST  = ID_W'(NUM_REQ - 1);
    localparam logic [ID_W:0]     NUM_EXT  = (ID_W + 1)'(NUM_REQ);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    function automatic logic [31:0] xs(input logic [31:0] x_in);
        logic [31:0] x;
        x = x_in ^ (x_in << 5'd13);
        x = x ^ (x >> 5'd17);
        x = x ^ (x << 5'd5);
        return x;
    endfunction

    state_e            state_q, state_d;
    logic [ID_W-1:0]   ptr_q, ptr_d;
    logic [31:0]       gen_q, gen_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic              out_valid_q, out_valid_d;
    logic [31:0]       rand_num_q, rand_num_d;
    logic [ID_W-1:0]   out_id_q, out_id_d;
    logic              busy_q, busy_d;

    logic              found_s;
    logic [ID_W-1:0]   win_s;
    logic [ID_W:0]     idx_s;
    logic              grant_s;
    logic [31:0]       seed_s;

    // Rotating priority search: first pending request at or above ptr, wrapping.
    always_comb begin
        found_s = 1'b0;
        win_s   = {ID_W{1'b0}};
        idx_s   = {(ID_W + 1){1'b0}};
        for (int i = 0; i < NUM_REQ; i++) begin
            idx_s = {1'b0, ptr_q} + (ID_W + 1)'(i);
            if (idx_s >= NUM_EXT) begin
                idx_s = idx_s - NUM_EXT;
            end else begin
                idx_s = idx_s;
            end
            if (!found_s && req_valid[idx_s[ID_W-1:0]]) begin
                found_s = 1'b1;
                win_s   = idx_s[ID_W-1:0];
            end else begin
                found_s = found_s;
                win_s   = win_s;
            end
        end
    end

    // Grant strobe and the winner's seed slice.
    always_comb begin
        grant_s   = (state_q == ST_IDLE) && found_s;
        req_ready = {NUM_REQ{1'b0}};
        seed_s    = 32'h0000_0000;
        if (grant_s) begin
            req_ready[win_s] = 1'b1;
        end else begin
            req_ready = {NUM_REQ{1'b0}};
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_s == ID_W'(i)) begin
                seed_s = req_seed[32*i +: 32];
            end else begin
                seed_s = seed_s;
            end
        end
    end

    // Job sequencing; output registers are loaded from the next-state values so
    // they line up with the state they describe and carry no path from out_ready.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gen_d   = gen_q;
        cnt_d   = cnt_q;
        id_d    = id_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_s) begin
                    gen_d   = xs(seed_s);
                    cnt_d   = {CNT_W{1'b0}};
                    id_d    = win_s;
                    ptr_d   = (win_s == ID_LAST) ? {ID_W{1'b0}} : win_s + ID_W'(1);
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (out_ready) begin
                    gen_d = xs(gen_q);
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_LAST) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_RUN;
                    end
                end else begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (state_d == ST_RUN) begin
            out_valid_d = 1'b1;
            busy_d      = 1'b1;
            rand_num_d  = gen_d;
            out_id_d    = id_d;
        end else begin
            out_valid_d = 1'b0;
            busy_d      = 1'b0;
            rand_num_d  = 32'h0000_0000;
            out_id_d    = {ID_W{1'b0}};
        end
    end

    // State and output registers; reset drops any job in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            ptr_q       <= {ID_W{1'b0}};
            gen_q       <= 32'h0000_0000;
            cnt_q       <= {CNT_W{1'b0}};
            id_q        <= {ID_W{1'b0}};
            out_valid_q <= 1'b0;
            rand_num_q  <= 32'h0000_0000;
            out_id_q    <= {ID_W{1'b0}};
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            gen_q       <= gen_d;
            cnt_q       <= cnt_d;
            id_q        <= id_d;
            out_valid_q <= out_valid_d;
            rand_num_q  <= rand_num_d;
            out_id_q    <= out_id_d;
            busy_q      <= busy_d;
        end
    end

    assign out_valid = out_valid_q;
    assign rand_num  = rand_num_q;
    assign out_id    = out_id_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_xorshift_sched.sv
// Randomized self-checking bench for xorshift_sched against an arithmetic
// xorshift32 model and a round-robin pointer model.
module tb_xorshift_sched;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req_valid;
    logic [63:0] req_seed;
    logic [1:0]  req_ready;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] rand_num;
    logic [0:0]  out_id;
    logic        busy;

    logic [1:0]  s1_req_valid;
    logic [63:0] s1_req_seed;
    logic [1:0]  s1_req_ready;
    logic        s1_out_valid;
    logic        s1_out_ready;
    logic [31:0] s1_rand_num;
    logic [0:0]  s1_out_id;
    logic        s1_busy;

    int tests_run    = 0;
    int tests_failed = 0;
    int ptr_m        = 0;

    always #5 clk = ~clk;

    xorshift_sched #(.NUM_REQ(2), .OUT_NUM(256)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_seed(req_seed),
        .req_ready(req_ready), .out_valid(out_valid), .out_ready(out_ready),
        .rand_num(rand_num), .out_id(out_id), .busy(busy)
    );

    xorshift_sched #(.NUM_REQ(2), .OUT_NUM(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .req_valid(s1_req_valid), .req_seed(s1_req_seed),
        .req_ready(s1_req_ready), .out_valid(s1_out_valid), .out_ready(s1_out_ready),
        .rand_num(s1_rand_num), .out_id(s1_out_id), .busy(s1_busy)
    );

    // xorshift32 via multiply/divide on a 64-bit value, truncated modulo 2^32
    function automatic logic [31:0] gold(input logic [31:0] x);
        longint unsigned t;
        t = 64'(x);
        t = t ^ ((t * 64'd8192) % 64'd4294967296);
        t = t ^ (t / 64'd131072);
        t = t ^ ((t * 64'd32) % 64'd4294967296);
        return t[31:0];
    endfunction

    function automatic int winner(input logic [1:0] v, input int p);
        for (int k = 0; k < 2; k++) begin
            if (v[(p + k) % 2]) return (p + k) % 2;
        end
        return -1;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; req_valid = 2'b00; out_ready = 1'b0;
        s1_req_valid = 2'b00; s1_out_ready = 1'b0;
        step(); step();
        rst_n = 1'b1;
        step();
        ptr_m = 0;
    endtask

    // Waits (bounded) for one accepted word; ready asserted with probability pct%.
    task automatic get_word(input int pct, output logic [31:0] w, output int id, output bit ok);
        ok = 1'b0; w = 32'h0; id = -1;
        for (int c = 0; c < 1000 && !ok; c++) begin
            out_ready = (pct >= 100) ? 1'b1 : ($urandom_range(0, 99) < pct);
            #1;
            if (out_valid && out_ready) begin
                w = rand_num; id = int'(out_id); ok = 1'b1;
            end
            step();
        end
        out_ready = 1'b0;
    endtask

    task automatic grant_one(input int r, input logic [31:0] seed, input string nm);
        logic [1:0] exp_rdy;
        req_seed[32*r +: 32] = seed;
        req_valid = 2'b00;
        req_valid[r] = 1'b1;
        #1;
        exp_rdy = 2'b01 << winner(req_valid, ptr_m);
        tests_run++;
        if (req_ready !== exp_rdy) begin
            tests_failed++;
            $display("FAIL %s_grant: req_ready=%b expected %b", nm, req_ready, exp_rdy);
        end
        step();
        req_valid = 2'b00;
        ptr_m = (r + 1) % 2;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_valid = 2'b10; out_ready = 1'b0;
        s1_req_valid = 2'b00; s1_out_ready = 1'b0; req_seed = 64'h0; s1_req_seed = 64'h0;
        #1;
        tests_run++;
        if ({out_valid, busy, rand_num, out_id} !== 35'h0) begin
            tests_failed++;
            $display("FAIL reset_outputs: valid=%b busy=%b rand=%h id=%0d expected all zero",
                     out_valid, busy, rand_num, out_id);
        end
        tests_run++;
        if (req_ready !== 2'b10) begin
            tests_failed++;
            $display("FAIL reset_ready_single: req_ready=%b expected 10", req_ready);
        end
        req_valid = 2'b11;
        #1;
        tests_run++;
        if (req_ready !== 2'b01) begin
            tests_failed++;
            $display("FAIL reset_ready_ptr0: req_ready=%b expected 01", req_ready);
        end
        req_valid = 2'b00;
        step(); step();
        rst_n = 1'b1;
        step();
        ptr_m = 0;
    endtask

    task automatic test_single();
        logic [31:0] known [3];
        logic [31:0] exp, w;
        int id;
        bit ok;
        known[0] = 32'h0004_2021; known[1] = 32'h0408_0601; known[2] = 32'h9DCC_A8C5;
        grant_one(0, 32'h0000_0001, "single");
        tests_run++;
        if (out_valid !== 1'b1 || busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL single_latency: valid=%b busy=%b expected 1 1", out_valid, busy);
        end
        exp = 32'h0000_0001;
        for (int n = 0; n < 256; n++) begin
            exp = gold(exp);
            get_word(100, w, id, ok);
            tests_run++;
            if (!ok || w !== exp || id !== 0 || (n < 3 && w !== known[n])) begin
                tests_failed++;
                $display("FAIL single_word[%0d]: got %h id %0d ok %0d expected %h id 0",
                         n, w, id, ok, (n < 3) ? known[n] : exp);
            end
        end
        tests_run++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || rand_num !== 32'h0) begin
            tests_failed++;
            $display("FAIL single_end: valid=%b busy=%b rand=%h expected 0 0 0", out_valid, busy, rand_num);
        end
    endtask

    task automatic test_round_robin();
        logic [31:0] gen_m, exp_rand;
        logic [1:0]  exp_rdy;
        logic        exp_valid;
        int          w_m, exp_id, r;
        do_reset();
        req_seed = {32'h8081_A201, 32'h0000_0001};
        req_valid = 2'b11;
        out_ready = 1'b1;
        w_m = 0; gen_m = 32'h0;
        for (int c = 0; c < 4 * 257; c++) begin
            r = c % 257;
            if (r == 0) begin
                w_m = winner(req_valid, ptr_m);
                ptr_m = (w_m + 1) % 2;
                gen_m = req_seed[32*w_m +: 32];
                exp_rdy = 2'b01 << w_m; exp_valid = 1'b0; exp_rand = 32'h0; exp_id = 0;
            end else begin
                gen_m = gold(gen_m);
                exp_rdy = 2'b00; exp_valid = 1'b1; exp_rand = gen_m; exp_id = w_m;
            end
            #1;
            tests_run++;
            if (out_valid !== exp_valid || rand_num !== exp_rand || int'(out_id) !== exp_id
                || req_ready !== exp_rdy) begin
                tests_failed++;
                $display("FAIL rr_cycle[%0d]: valid=%b rand=%h id=%0d rdy=%b expected %b %h %0d %b",
                         c, out_valid, rand_num, out_id, req_ready, exp_valid, exp_rand, exp_id, exp_rdy);
            end
            step();
        end
        req_valid = 2'b00;
        out_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        logic [31:0] exp, seed, prev_w;
        logic [0:0]  prev_id;
        bit          stalled;
        int          r, widx;
        for (int j = 0; j < 2; j++) begin
            r = $urandom_range(0, 1);
            seed = $urandom;
            grant_one(r, seed, "bp");
            exp = gold(seed); widx = 0; stalled = 1'b0; prev_w = 32'h0; prev_id = 1'b0;
            for (int c = 0; c < 3000 && widx < 256; c++) begin
                out_ready = $urandom_range(0, 1) == 1;
                #1;
                tests_run++;
                if (out_valid !== 1'b1 || rand_num !== exp || int'(out_id) !== r) begin
                    tests_failed++;
                    $display("FAIL bp_word[%0d]: valid=%b rand=%h id=%0d expected 1 %h %0d",
                             widx, out_valid, rand_num, out_id, exp, r);
                end
                if (stalled) begin
                    tests_run++;
                    if (rand_num !== prev_w || out_id !== prev_id) begin
                        tests_failed++;
                        $display("FAIL bp_hold: rand=%h id=%0d expected %h %0d", rand_num, out_id, prev_w, prev_id);
                    end
                end
                if (out_valid && out_ready) begin
                    widx++;
                    exp = gold(exp);
                end
                stalled = out_valid && !out_ready;
                prev_w = rand_num; prev_id = out_id;
                step();
            end
            tests_run++;
            if (widx != 256) begin
                tests_failed++;
                $display("FAIL bp_count: words=%0d expected 256", widx);
            end
            for (int c = 0; c < 3; c++) begin
                out_ready = $urandom_range(0, 1) == 1;
                #1;
                tests_run++;
                if (out_valid !== 1'b0 || rand_num !== 32'h0 || out_id !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL bp_quiet: valid=%b rand=%h id=%0d expected 0 0 0", out_valid, rand_num, out_id);
                end
                step();
            end
            out_ready = 1'b0;
        end
    endtask

    task automatic test_seed0_and_out1();
        logic [31:0] w;
        int id;
        bit ok;
        grant_one(0, 32'h0000_0000, "seed0");
        for (int n = 0; n < 256; n++) begin
            get_word(100, w, id, ok);
            tests_run++;
            if (!ok || w !== 32'h0 || id !== 0) begin
                tests_failed++;
                $display("FAIL seed0_word[%0d]: got %h id %0d ok %0d expected 0 id 0", n, w, id, ok);
            end
        end
        tests_run++;
        if (out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL seed0_end: valid=%b expected 0", out_valid);
        end
        s1_req_seed = {32'h0, 32'h0000_0001};
        s1_req_valid = 2'b01;
        #1;
        tests_run++;
        if (s1_req_ready !== 2'b01) begin
            tests_failed++;
            $display("FAIL out1_grant: req_ready=%b expected 01", s1_req_ready);
        end
        step();
        s1_req_valid = 2'b00;
        s1_out_ready = 1'b1;
        tests_run++;
        if (s1_out_valid !== 1'b1 || s1_rand_num !== 32'h0004_2021 || s1_out_id !== 1'b0) begin
            tests_failed++;
            $display("FAIL out1_word: valid=%b rand=%h id=%0d expected 1 00042021 0",
                     s1_out_valid, s1_rand_num, s1_out_id);
        end
        step();
        tests_run++;
        if (s1_out_valid !== 1'b0 || s1_busy !== 1'b0 || s1_rand_num !== 32'h0) begin
            tests_failed++;
            $display("FAIL out1_end: valid=%b busy=%b rand=%h expected 0 0 0", s1_out_valid, s1_busy, s1_rand_num);
        end
        s1_out_ready = 1'b0;
    endtask

    task automatic test_mid_reset();
        logic [31:0] exp, w;
        int id;
        bit ok;
        grant_one(0, 32'h0000_0001, "mrst");
        exp = 32'h0000_0001;
        for (int n = 0; n < 100; n++) begin
            exp = gold(exp);
            get_word(100, w, id, ok);
        end
        tests_run++;
        if (!ok || w !== exp || busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL mrst_word100: got %h ok %0d busy %b expected %h busy 1", w, ok, busy, exp);
        end
        #2;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if ({out_valid, busy, rand_num, out_id} !== 35'h0) begin
            tests_failed++;
            $display("FAIL mrst_async_clear: valid=%b busy=%b rand=%h id=%0d expected all zero",
                     out_valid, busy, rand_num, out_id);
        end
        step();
        rst_n = 1'b1;
        step();
        ptr_m = 0;
        req_seed = {$urandom, 32'h0000_0001};
        req_valid = 2'b11;
        #1;
        tests_run++;
        if (req_ready !== 2'b01) begin
            tests_failed++;
            $display("FAIL mrst_ptr: req_ready=%b expected 01", req_ready);
        end
        step();
        req_valid = 2'b00;
        tests_run++;
        if (out_valid !== 1'b1 || rand_num !== 32'h0004_2021 || out_id !== 1'b0) begin
            tests_failed++;
            $display("FAIL mrst_restart: valid=%b rand=%h id=%0d expected 1 00042021 0",
                     out_valid, rand_num, out_id);
        end
        do_reset();
    endtask

    task automatic test_withdraw();
        logic [31:0] exp, w;
        int id;
        bit ok;
        exp = $urandom;
        grant_one(0, exp, "wd");
        for (int n = 0; n < 256; n++) begin
            if (n == 50) begin
                req_seed[63:32] = $urandom;
                req_valid[1] = 1'b1;
            end
            if (n == 200) req_valid[1] = 1'b0;
            exp = gold(exp);
            get_word(100, w, id, ok);
            tests_run++;
            if (!ok || w !== exp || id !== 0 || (n >= 50 && n < 200 && req_ready !== 2'b00)) begin
                tests_failed++;
                $display("FAIL wd_word[%0d]: got %h id %0d ok %0d rdy %b expected %h id 0 rdy 00",
                         n, w, id, ok, req_ready, exp);
            end
        end
        for (int c = 0; c < 10; c++) begin
            #1;
            tests_run++;
            if (out_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 2'b00) begin
                tests_failed++;
                $display("FAIL wd_idle[%0d]: valid=%b busy=%b rdy=%b expected 0 0 00", c, out_valid, busy, req_ready);
            end
            step();
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_seed0_and_out1();
        test_mid_reset();
        test_withdraw();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
